// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load sources, the arbiter and the register file write port.
// Defining REGFILE_WB_ARB_FWD_EN adds the forwarding outputs.
interface regfile_wb_arbiter_if #(parameter int XLEN = 32, parameter int AW = 5);
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid, mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   rs1, rs2;
  logic            hz1, hz2, busy;
`ifdef REGFILE_WB_ARB_FWD_EN
  logic            fwd1_valid, fwd2_valid;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
`endif

  modport master (
`ifdef REGFILE_WB_ARB_FWD_EN
    input  fwd1_valid, fwd1_data, fwd2_valid, fwd2_data,
`endif
    output alu_valid, alu_rd, alu_data, input alu_ready,
    output mem_valid, mem_rd, mem_data, input mem_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output rs1, rs2, input hz1, hz2, busy
  );

  modport slave (
`ifdef REGFILE_WB_ARB_FWD_EN
    output fwd1_valid, fwd1_data, fwd2_valid, fwd2_data,
`endif
    input  alu_valid, alu_rd, alu_data, output alu_ready,
    input  mem_valid, mem_rd, mem_data, output mem_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  rs1, rs2, output hz1, hz2, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: buffered ALU writeback vs. direct load writeback, round-robin.
// Defining REGFILE_WB_ARB_FWD_EN adds per-read-port forwarding of pending write data.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  regfile_wb_arbiter_if.slave wb
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_ent_t;

  typedef enum logic {SRC_MEM = 1'b0, SRC_ALU = 1'b1} src_e;

  wb_ent_t        fifo_q [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  src_e           last_grant, last_grant_d;
  logic           head_cand, mem_cand, grant_alu, grant_mem, push;
  logic [DEPTH-1:0] ent_vld, m1, m2;

  assign head_cand    = (count != '0);
  assign mem_cand     = wb.mem_valid & (wb.mem_rd != '0);
  assign grant_alu    = head_cand & (~mem_cand | (last_grant == SRC_MEM));
  assign grant_mem    = mem_cand & (~head_cand | (last_grant == SRC_ALU));
  assign wb.alu_ready = (count < (PW+1)'(DEPTH));
  assign wb.mem_ready = wb.mem_valid & ((wb.mem_rd == '0) | grant_mem);
  assign push         = wb.alu_valid & wb.alu_ready & (wb.alu_rd != '0);
  assign wb.busy      = head_cand | wb.rf_we;

  always_comb begin
    last_grant_d = last_grant;
    if (grant_alu)      last_grant_d = SRC_ALU;
    else if (grant_mem) last_grant_d = SRC_MEM;
  end

  // Slot validity by age offset from the read pointer, so wrap needs no special case.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr;
    assign ent_vld[i] = ({1'b0, off} < count);
    assign m1[i]      = ent_vld[i] & (fifo_q[i].rd == wb.rs1);
    assign m2[i]      = ent_vld[i] & (fifo_q[i].rd == wb.rs2);
  end

  assign wb.hz1 = (wb.rs1 != '0) & ((|m1) | (wb.rf_we & (wb.rf_waddr == wb.rs1)));
  assign wb.hz2 = (wb.rs2 != '0) & ((|m2) | (wb.rf_we & (wb.rf_waddr == wb.rs2)));

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{rd: wb.alu_rd, data: wb.alu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_grant  <= SRC_MEM;
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (grant_alu) rd_ptr <= rd_ptr + 1'b1;
      count      <= count + (PW+1)'(push) - (PW+1)'(grant_alu);
      last_grant <= last_grant_d;
      wb.rf_we   <= grant_alu | grant_mem;
      if (grant_alu) begin
        wb.rf_waddr <= fifo_q[rd_ptr].rd;
        wb.rf_wdata <= fifo_q[rd_ptr].data;
      end else if (grant_mem) begin
        wb.rf_waddr <= wb.mem_rd;
        wb.rf_wdata <= wb.mem_data;
      end
    end
  end

`ifdef REGFILE_WB_ARB_FWD_EN
  logic            hit1, hit2;
  logic [XLEN-1:0] yd1, yd2;
  logic [PW-1:0]   fidx;

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    yd1  = '0;
    yd2  = '0;
    fidx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr + PW'(k);
      if (m1[fidx]) begin hit1 = 1'b1; yd1 = fifo_q[fidx].data; end
      if (m2[fidx]) begin hit2 = 1'b1; yd2 = fifo_q[fidx].data; end
    end
  end

  assign wb.fwd1_valid = wb.hz1;
  assign wb.fwd2_valid = wb.hz2;
  assign wb.fwd1_data  = !wb.hz1 ? '0 : (hit1 ? yd1 : wb.rf_wdata);
  assign wb.fwd2_data  = !wb.hz2 ? '0 : (hit2 ? yd2 : wb.rf_wdata);
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs. a queue-based model.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 32, AW = 5, DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) wb();
  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .wb(wb));

  int checks = 0, errors = 0;

  typedef struct {logic [AW-1:0] rd; logic [XLEN-1:0] data;} ent_t;
  ent_t            mq[$];
  bit              m_last_alu;
  logic            m_we;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  logic            e_alu_ready, e_mem_ready, e_hz1, e_hz2, e_busy, w_alu, w_mem;
  logic [XLEN-1:0] e_fwd1, e_fwd2;

  function automatic logic hz_of(logic [AW-1:0] rs);
    if (rs == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == rs) return 1'b1;
    return m_we && (m_waddr == rs);
  endfunction

  function automatic logic [XLEN-1:0] fwd_of(logic [AW-1:0] rs);
    if (!hz_of(rs)) return '0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == rs) return mq[i].data;
    return m_wdata;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last_alu = 1'b0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_eval();
    logic head, memc;
    head        = mq.size() > 0;
    memc        = wb.mem_valid && (wb.mem_rd != 0);
    e_alu_ready = mq.size() < DEPTH;
    w_alu       = head && (!memc || !m_last_alu);
    w_mem       = memc && (!head || m_last_alu);
    e_mem_ready = wb.mem_valid && ((wb.mem_rd == 0) || w_mem);
    e_hz1       = hz_of(wb.rs1);
    e_hz2       = hz_of(wb.rs2);
    e_fwd1      = fwd_of(wb.rs1);
    e_fwd2      = fwd_of(wb.rs2);
    e_busy      = head || m_we;
  endtask

  task automatic model_commit();
    if (w_alu) begin
      m_we = 1'b1; m_waddr = mq[0].rd; m_wdata = mq[0].data;
      void'(mq.pop_front());
      m_last_alu = 1'b1;
    end else if (w_mem) begin
      m_we = 1'b1; m_waddr = wb.mem_rd; m_wdata = wb.mem_data;
      m_last_alu = 1'b0;
    end else m_we = 1'b0;
    if (wb.alu_valid && e_alu_ready && wb.alu_rd != 0) mq.push_back('{wb.alu_rd, wb.alu_data});
  endtask

  task automatic half_a(); @(negedge clk); model_eval(); endtask
  task automatic half_b(); @(posedge clk); model_commit(); #1; endtask

  task automatic idle_inputs();
    wb.alu_valid = 0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.mem_valid = 0; wb.mem_rd = '0; wb.mem_data = '0;
    wb.rs1 = '0; wb.rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    @(negedge clk); rst = 1'b0; model_reset(); model_eval();
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    wb.rs1 = 5'd1; wb.rs2 = 5'd2;
    rst = 1'b1;
    #3;
    for (int pass = 0; pass < 2; pass++) begin
      checks += 6;
      if (wb.rf_we !== 1'b0)   begin errors++; $display("FAIL reset_rf_we p%0d: got %b exp 0", pass, wb.rf_we); end
      if (wb.rf_waddr !== '0)  begin errors++; $display("FAIL reset_waddr p%0d: got %0h exp 0", pass, wb.rf_waddr); end
      if (wb.rf_wdata !== '0)  begin errors++; $display("FAIL reset_wdata p%0d: got %0h exp 0", pass, wb.rf_wdata); end
      if (wb.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy p%0d: got %b exp 0", pass, wb.busy); end
      if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready p%0d: got %b exp 1", pass, wb.alu_ready); end
      if ({wb.hz1, wb.hz2} !== 2'b00) begin errors++; $display("FAIL reset_hz p%0d: got %b exp 00", pass, {wb.hz1, wb.hz2}); end
      if (pass == 0) begin
        @(negedge clk); rst = 1'b0; model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    wb.alu_valid = 1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF; wb.rs1 = 5'd5;
    half_a();
    checks++;
    if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", wb.alu_ready); end
    half_b();
    wb.alu_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      half_a();
      checks += 2;
      if (wb.hz1 !== (c <= 2)) begin errors++; $display("FAIL single_hz1 c%0d: got %b exp %b", c, wb.hz1, c <= 2); end
      if (wb.rf_we !== (c == 2)) begin errors++; $display("FAIL single_we c%0d: got %b exp %b", c, wb.rf_we, c == 2); end
      if (c == 2) begin
        checks++;
        if ({wb.rf_waddr, wb.rf_wdata} !== {5'd5, 32'hDEADBEEF})
          begin errors++; $display("FAIL single_wr: got %0h/%0h exp 5/deadbeef", wb.rf_waddr, wb.rf_wdata); end
      end
      half_b();
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_seq [8];
    logic [AW-1:0] log_q [$];
    int alu_n = 0, mem_n = 0;
    exp_seq = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4, 5'd13};
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      wb.alu_valid = alu_n < 4; wb.alu_rd = AW'(1 + alu_n);  wb.alu_data = 32'hA0 + alu_n;
      wb.mem_valid = cyc >= 1 && mem_n < 4; wb.mem_rd = AW'(10 + mem_n); wb.mem_data = 32'hB0 + mem_n;
      half_a();
      checks += 2;
      if (wb.mem_ready !== e_mem_ready) begin errors++; $display("FAIL rr_mem_ready c%0d: got %b exp %b", cyc, wb.mem_ready, e_mem_ready); end
      if (wb.rf_we !== m_we) begin errors++; $display("FAIL rr_we c%0d: got %b exp %b", cyc, wb.rf_we, m_we); end
      if (wb.rf_we) log_q.push_back(wb.rf_waddr);
      if (wb.alu_valid && e_alu_ready) alu_n++;
      if (wb.mem_valid && e_mem_ready) mem_n++;
      half_b();
    end
    checks++;
    if (log_q.size() != 8) begin errors++; $display("FAIL rr_count: got %0d exp 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_seq[%0d]: got %0d exp %0d", i, log_q[i], exp_seq[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] log_q [$];
    int n = 0, stalls = 0;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      wb.alu_valid = n < 8; wb.alu_rd = AW'(16 + n); wb.alu_data = $urandom;
      wb.mem_valid = 1; wb.mem_rd = 5'd7; wb.mem_data = $urandom;
      half_a();
      checks++;
      if (wb.alu_ready !== e_alu_ready) begin errors++; $display("FAIL bp_alu_ready c%0d: got %b exp %b", cyc, wb.alu_ready, e_alu_ready); end
      if (!wb.alu_ready) stalls++;
      if (wb.rf_we && wb.rf_waddr != 5'd7) log_q.push_back(wb.rf_waddr);
      if (wb.alu_valid && e_alu_ready) n++;
      half_b();
    end
    checks += 2;
    if (stalls == 0) begin errors++; $display("FAIL bp_stall: got 0 stall cycles exp >0"); end
    if (log_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d exp 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== AW'(16 + i)) begin errors++; $display("FAIL bp_order[%0d]: got %0d exp %0d", i, log_q[i], 16 + i); end
    end
  endtask

  task automatic test_x0();
    do_reset();
    wb.alu_valid = 1; wb.alu_rd = '0; wb.alu_data = 32'h1234;
    wb.mem_valid = 1; wb.mem_rd = '0; wb.mem_data = 32'h5678;
    for (int c = 0; c < 4; c++) begin
      half_a();
      checks++;
      if ({wb.alu_ready, wb.mem_ready, wb.rf_we, wb.hz1, wb.busy} !== 5'b11000)
        begin errors++; $display("FAIL x0 c%0d: got rdy/mrdy/we/hz1/busy=%b exp 11000", c,
          {wb.alu_ready, wb.mem_ready, wb.rf_we, wb.hz1, wb.busy}); end
      half_b();
    end
  endtask

`ifdef REGFILE_WB_ARB_FWD_EN
  task automatic test_fwd();
    int both = 0;
    do_reset();
    wb.rs1 = 5'd3;
    for (int cyc = 0; cyc < 8; cyc++) begin
      wb.alu_valid = cyc < 3;
      wb.alu_rd    = (cyc == 0) ? 5'd4 : 5'd3;
      wb.alu_data  = (cyc == 0) ? 32'h44 : (cyc == 1) ? 32'h11 : 32'h22;
      wb.mem_valid = cyc == 1 || cyc == 2; wb.mem_rd = 5'd9; wb.mem_data = 32'h99;
      half_a();
      checks += 2;
      if (wb.fwd1_valid !== e_hz1) begin errors++; $display("FAIL fwd_valid c%0d: got %b exp %b", cyc, wb.fwd1_valid, e_hz1); end
      if (wb.fwd1_data !== e_fwd1) begin errors++; $display("FAIL fwd_data c%0d: got %0h exp %0h", cyc, wb.fwd1_data, e_fwd1); end
      if (mq.size() >= 2 && mq[0].rd == 3 && mq[1].rd == 3) begin
        both++; checks++;
        if (wb.fwd1_data !== 32'h22) begin errors++; $display("FAIL fwd_youngest c%0d: got %0h exp 22", cyc, wb.fwd1_data); end
      end
      half_b();
    end
    checks++;
    if (both == 0) begin errors++; $display("FAIL fwd_scenario: got 0 cycles with both queued exp >0"); end
  endtask
`endif

  task automatic test_reset_mid_drain();
    do_reset();
    wb.rs1 = 5'd6;
    for (int cyc = 0; cyc < 3; cyc++) begin
      wb.alu_valid = 1; wb.alu_rd = AW'(6 + cyc); wb.alu_data = $urandom;
      wb.mem_valid = 1; wb.mem_rd = 5'd12; wb.mem_data = $urandom;
      half_a(); half_b();
    end
    idle_inputs();
    wb.rs1 = 5'd7;
    rst = 1'b1;
    #1;
    checks++;
    if ({wb.rf_we, wb.busy, wb.hz1, wb.alu_ready} !== 4'b0001)
      begin errors++; $display("FAIL mid_rst: got we/busy/hz1/rdy=%b exp 0001", {wb.rf_we, wb.busy, wb.hz1, wb.alu_ready}); end
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      half_a();
      checks++;
      if ({wb.rf_we, wb.busy, wb.hz1} !== 3'b000)
        begin errors++; $display("FAIL post_rst c%0d: got we/busy/hz1=%b exp 000", c, {wb.rf_we, wb.busy, wb.hz1}); end
      half_b();
    end
  endtask

  task automatic test_random();
    bit alu_acc = 1, mem_acc = 1;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!wb.alu_valid || alu_acc) begin
        wb.alu_valid = ($urandom_range(0, 3) != 0); wb.alu_rd = AW'($urandom_range(0, 7)); wb.alu_data = $urandom;
      end
      if (!wb.mem_valid || mem_acc) begin
        wb.mem_valid = ($urandom_range(0, 2) == 0); wb.mem_rd = AW'($urandom_range(0, 7)); wb.mem_data = $urandom;
      end
      wb.rs1 = AW'($urandom_range(0, 7)); wb.rs2 = AW'($urandom_range(0, 7));
      half_a();
      checks += 5;
      if ({wb.alu_ready, wb.mem_ready} !== {e_alu_ready, e_mem_ready})
        begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", cyc, {wb.alu_ready, wb.mem_ready}, {e_alu_ready, e_mem_ready}); end
      if ({wb.rf_we, wb.rf_waddr, wb.rf_wdata} !== {m_we, m_waddr, m_wdata})
        begin errors++; $display("FAIL rnd_rf c%0d: got %b/%0h/%0h exp %b/%0h/%0h", cyc,
          wb.rf_we, wb.rf_waddr, wb.rf_wdata, m_we, m_waddr, m_wdata); end
      if ({wb.hz1, wb.hz2} !== {e_hz1, e_hz2})
        begin errors++; $display("FAIL rnd_hz c%0d: got %b exp %b", cyc, {wb.hz1, wb.hz2}, {e_hz1, e_hz2}); end
      if (wb.busy !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %b exp %b", cyc, wb.busy, e_busy); end
      if (wb.rf_we && wb.rf_waddr == 0) begin errors++; $display("FAIL rnd_x0_write c%0d: got waddr 0 exp nonzero", cyc); end
`ifdef REGFILE_WB_ARB_FWD_EN
      checks++;
      if ({wb.fwd1_data, wb.fwd2_data} !== {e_fwd1, e_fwd2})
        begin errors++; $display("FAIL rnd_fwd c%0d: got %0h/%0h exp %0h/%0h", cyc, wb.fwd1_data, wb.fwd2_data, e_fwd1, e_fwd2); end
`endif
      alu_acc = wb.alu_valid && e_alu_ready;
      mem_acc = wb.mem_valid && e_mem_ready;
      half_b();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    test_reset();
    test_single_alu();
    test_round_robin();
    test_backpressure();
    test_x0();
`ifdef REGFILE_WB_ARB_FWD_EN
    test_fwd();
`endif
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
